// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM-stage initiator and the data-memory responder.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  req_size;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        busy;

   modport master (
      output req_valid, req_write, req_size, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy
   );

   modport slave (
      input  req_valid, req_write, req_size, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err, busy
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for MEM-stage loads/stores, preloaded from `elements` on reset.
// Define DMEM_BYTE_EN for sub-word (lb/lh/lw/ld, sb/sh/sw/sd) accesses; otherwise all accesses are 64-bit.
module dmem_responder #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [511:0]     elements,
   dmem_responder_if.slave  bus
);
   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned CW      = 4;
   localparam int unsigned PRELOAD = 8;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic        write;
      logic [2:0]  size;
      logic [63:0] addr;
      logic [63:0] wdata;
   } req_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   req_t          live, lat, cur;
   logic [63:0]   mem [DEPTH];

   logic [AW-1:0] idx;
   logic [63:0]   word, ld, st;
   logic          oor, mis, bad_size, err;
   logic          resp_valid_q, resp_err_q;
   logic [63:0]   resp_rdata_q;

   assign live = {bus.req_write, bus.req_size, bus.req_addr, bus.req_wdata};
   // With zero latency the access is evaluated on the live request in the accept cycle.
   assign cur  = (state == IDLE) ? live : lat;

   assign bus.req_ready  = (state == IDLE);
   assign bus.busy       = (state != IDLE) | ((state == IDLE) & bus.req_valid);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (LATENCY == 0) begin
                  state_next = RESP;
               end else begin
                  cnt_next   = CW'(LATENCY - 1);
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) state_next = RESP;
            else           cnt_next   = cnt - CW'(1);
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                            lat <= '0;
      else if ((state == IDLE) && bus.req_valid) lat <= live;
   end

   // Address decode, access checks, load extraction and store merge.
   always_comb begin
      idx      = cur.addr[3 +: AW];
      word     = mem[idx];
      oor      = |cur.addr[63:3+AW];
      mis      = 1'b0;
      bad_size = 1'b0;
      ld       = word;
      st       = cur.wdata;
`ifdef DMEM_BYTE_EN
      begin
         logic [5:0]  sh;
         logic [63:0] raw, mask;
         sh   = {cur.addr[2:0], 3'b000};
         raw  = word >> sh;
         case (cur.size[1:0])
            2'd0:    begin mask = 64'h0000_0000_0000_00FF; mis = 1'b0;           end
            2'd1:    begin mask = 64'h0000_0000_0000_FFFF; mis = cur.addr[0];     end
            2'd2:    begin mask = 64'h0000_0000_FFFF_FFFF; mis = |cur.addr[1:0];  end
            default: begin mask = '1;                      mis = |cur.addr[2:0];  end
         endcase
         bad_size = (cur.size == 3'b111);
         case (cur.size)
            3'b000:  ld = {{56{raw[7]}},  raw[7:0]};
            3'b001:  ld = {{48{raw[15]}}, raw[15:0]};
            3'b010:  ld = {{32{raw[31]}}, raw[31:0]};
            3'b100:  ld = {56'd0, raw[7:0]};
            3'b101:  ld = {48'd0, raw[15:0]};
            3'b110:  ld = {32'd0, raw[31:0]};
            default: ld = raw;
         endcase
         st = (word & ~(mask << sh)) | ((cur.wdata & mask) << sh);
      end
`else
      mis = |cur.addr[2:0];
`endif
      err = oor | mis | bad_size;
   end

`ifndef DMEM_BYTE_EN
   logic unused_size;
   assign unused_size = ^cur.size;
`endif

   // Array: reloaded from `elements` on every reset; stores commit at the end of RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PRELOAD; i++) mem[i] <= elements[64*i +: 64];
         for (int i = PRELOAD; i < DEPTH; i++) mem[i] <= '0;
      end else if ((state == RESP) && cur.write && !err) begin
         mem[idx] <= st;
      end
   end

   // Response registers load on entry to RESP so data is valid alongside resp_valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= (state_next == RESP);
         resp_err_q   <= (state_next == RESP) && err;
         resp_rdata_q <= ((state_next == RESP) && !cur.write && !err) ? ld : '0;
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic against a byte-level memory model.
module tb_dmem_responder;
   localparam int unsigned DEPTH   = 64;
   localparam int unsigned LATENCY = 2;
   localparam int unsigned NBYTES  = DEPTH * 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [511:0] elements;
   int           checks   = 0;
   int           failures = 0;
   byte unsigned mb [NBYTES];

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk      (clk),
      .reset    (rst_n),
      .elements (elements),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
      for (int w = 0; w < 8; w++)
         for (int b = 0; b < 8; b++) mb[w*8+b] = elements[64*w + 8*b +: 8];
   endtask

   // Little-endian byte memory; accesses of n bytes must be n-aligned and inside the array.
   task automatic model_access(input logic wr, input logic [2:0] size, input logic [63:0] addr,
                               input logic [63:0] wdata, output logic [63:0] rdata, output logic err);
      int unsigned n;
      int unsigned base;
      logic [63:0] v;
      n = 8;
`ifdef DMEM_BYTE_EN
      n = 1 << size[1:0];
`endif
      err = (addr >= 64'(NBYTES)) || ((addr % 64'(n)) != 0);
`ifdef DMEM_BYTE_EN
      if (size == 3'b111) err = 1'b1;
`else
      if (size === 3'bxxx) err = 1'bx;
`endif
      rdata = '0;
      if (err) return;
      base = int'(addr);
      v = '0;
      if (wr) begin
         for (int i = 0; i < n; i++) mb[base+i] = wdata[8*i +: 8];
      end else begin
         for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base+i];
`ifdef DMEM_BYTE_EN
         if (!size[2] && n < 8 && v[8*n-1])
            for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
`endif
         rdata = v;
      end
   endtask

   // One request, then wait (bounded) for its response and compare against the model.
   task automatic single(input string tag, input logic wr, input logic [2:0] size,
                         input logic [63:0] addr, input logic [63:0] wdata);
      logic [63:0] exp_d;
      logic        exp_e;
      int          lat;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_size  = size;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      #1;
      check({tag, "/accept_ready"}, 64'(bus.req_ready), 64'd1);
      check({tag, "/accept_busy"},  64'(bus.busy),      64'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 20) begin
         check({tag, "/wait_busy"},  64'(bus.busy),      64'd1);
         check({tag, "/wait_ready"}, 64'(bus.req_ready), 64'd0);
         @(negedge clk);
         lat++;
      end
      check({tag, "/latency"}, 64'(lat), 64'(LATENCY + 1));
      model_access(wr, size, addr, wdata, exp_d, exp_e);
      check({tag, "/rdata"},     bus.resp_rdata,    exp_d);
      check({tag, "/err"},       64'(bus.resp_err), 64'(exp_e));
      check({tag, "/resp_busy"}, 64'(bus.busy),     64'd1);
      @(negedge clk);
      check({tag, "/pulse_end"}, 64'(bus.resp_valid), 64'd0);
      check({tag, "/idle_busy"}, 64'(bus.busy),       64'd0);
      check({tag, "/idle_rdy"},  64'(bus.req_ready),  64'd1);
   endtask

   logic [63:0] q_addr[$];
   logic [63:0] exp_q[$];
   logic [63:0] ed;
   logic        ee;
   logic        accepted;
   int          last_resp;
   logic [63:0] raddr;
   logic [2:0]  rsize;

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_size  = 3'b011;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      for (int i = 0; i < 8; i++) elements[64*i +: 64] = 64'(i + 1);
      model_reset();

      // Reset state, then the preloaded top word after release.
      repeat (2) @(negedge clk);
      check("reset/ready",      64'(bus.req_ready),  64'd1);
      check("reset/resp_valid", 64'(bus.resp_valid), 64'd0);
      check("reset/err",        64'(bus.resp_err),   64'd0);
      check("reset/rdata",      bus.resp_rdata,      64'd0);
      check("reset/busy",       64'(bus.busy),       64'd0);
      rst_n = 1'b1;
      single("t1_load38", 1'b0, 3'b011, 64'h38, '0);
      check("t1_value", bus.resp_rdata, 64'd0);

      // Store then load above the preloaded region.
      single("t2_store40", 1'b1, 3'b011, 64'h40, 64'hDEAD_BEEF_CAFE_F00D);
      single("t2_load40",  1'b0, 3'b011, 64'h40, '0);

      // Misaligned and out-of-range; an out-of-range store must not alias onto word 0.
      single("t3_mis1003", 1'b0, 3'b011, 64'h1003, '0);
      single("t3_oor8000", 1'b0, 3'b011, 64'h8000, '0);
      single("t3_st8000",  1'b1, 3'b011, 64'h8000, 64'h1234_5678_9ABC_DEF0);
      single("t3_load0",   1'b0, 3'b011, 64'h0, '0);

      // Held req_valid with three queued loads; responses must be LATENCY+2 cycles apart.
      q_addr = '{64'h0, 64'h8, 64'h10};
      foreach (q_addr[i]) begin
         model_access(1'b0, 3'b011, q_addr[i], '0, ed, ee);
         exp_q.push_back(ed);
      end
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_size  = 3'b011;
      bus.req_addr  = q_addr.pop_front();
      last_resp = -1;
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
         #1;
         if (bus.resp_valid) begin
            check("t4_rdata", bus.resp_rdata, exp_q.pop_front());
            if (last_resp >= 0) check("t4_spacing", 64'(c - last_resp), 64'(LATENCY + 2));
            last_resp = c;
         end
         if (bus.req_valid) check("t4_busy", 64'(bus.busy), 64'd1);
         accepted = bus.req_valid && bus.req_ready;
         @(negedge clk);
         if (accepted) begin
            if (q_addr.size() > 0) bus.req_addr = q_addr.pop_front();
            else                   bus.req_valid = 1'b0;
         end
      end
      check("t4_all_responses", 64'(exp_q.size()), 64'd0);
      bus.req_valid = 1'b0;

      // Reset during WAIT of a store: no response, store lost, array reloaded.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_size  = 3'b011;
      bus.req_addr  = 64'h08;
      bus.req_wdata = 64'h5555_AAAA_5555_AAAA;
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t5_rst_ready", 64'(bus.req_ready), 64'd1);
      check("t5_rst_busy",  64'(bus.busy),      64'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("t5_no_resp", 64'(bus.resp_valid), 64'd0);
      end
      rst_n = 1'b1;
      model_reset();
      single("t5_load08", 1'b0, 3'b011, 64'h08, '0);
      single("t5_load40", 1'b0, 3'b011, 64'h40, '0);

`ifdef DMEM_BYTE_EN
      // Sub-word store and signed/unsigned byte loads.
      single("t6_sb11",  1'b1, 3'b000, 64'h11, 64'h80);
      single("t6_lb11",  1'b0, 3'b000, 64'h11, '0);
      single("t6_lbu11", 1'b0, 3'b100, 64'h11, '0);
      single("t6_ld10",  1'b0, 3'b011, 64'h10, '0);
`endif

      // Random traffic: mostly in-range, some misaligned offsets and out-of-range high bits.
      for (int k = 0; k < 40; k++) begin
         raddr = 64'($urandom_range(0, DEPTH - 1)) << 3;
         if ($urandom_range(0, 3) == 0) raddr = raddr + 64'($urandom_range(1, 7));
         if ($urandom_range(0, 7) == 0) raddr = raddr | (64'd1 << $urandom_range(9, 63));
         rsize = 3'($urandom_range(0, 7));
         single("rand", 1'($urandom_range(0, 1)), rsize, raddr, {32'($urandom), 32'($urandom)});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
